jtag_tap_sampled: RTL and testbench

//  IEEE 1149.1 TAP controller that consumes the JTAG pins driven by the DPI JTAG

---
 rtl/jtag_tap_sampled.sv | 160 ++++++++++++++++
 tb/tb_jtag_tap_sampled.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP controller with TCK oversampled in the clk domain (IDCODE, BYPASS, 32-bit DBG register).
// Define JTAG_TAP_SYNC_EN to add 2-flop synchronizers on tck/tms/tdi/trstn for asynchronous pins.
module jtag_tap_sampled #(
    parameter int unsigned          IR_WIDTH    = 5,
    parameter logic [31:0]          IDCODE      = 32'h1DEAD3FF,
    parameter logic [IR_WIDTH-1:0]  INSN_IDCODE = IR_WIDTH'(5'h01),
    parameter logic [IR_WIDTH-1:0]  INSN_DBG    = IR_WIDTH'(5'h10)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    input  logic        trstn,
    output logic        tdo,
    input  logic [31:0] dbg_rdata,
    output logic [31:0] dbg_wdata,
    output logic        dbg_wvalid,
    output logic [3:0]  tap_state
);
    typedef enum logic [3:0] {
        S_EX2DR  = 4'h0, S_EX1DR   = 4'h1, S_SHDR  = 4'h2, S_PAUSEDR = 4'h3,
        S_SELIR  = 4'h4, S_UPDDR   = 4'h5, S_CAPDR = 4'h6, S_SELDR   = 4'h7,
        S_EX2IR  = 4'h8, S_EX1IR   = 4'h9, S_SHIR  = 4'hA, S_PAUSEIR = 4'hB,
        S_RTI    = 4'hC, S_UPDIR   = 4'hD, S_CAPIR = 4'hE, S_TLR     = 4'hF
    } tap_state_t;

    tap_state_t          r_state;
    tap_state_t          w_state_nxt;
    logic                w_tck, w_tms, w_tdi, w_trstn;
    logic                r_tck_q;
    logic                w_rise, w_fall;
    logic [IR_WIDTH-1:0] r_ir, r_ir_sh;
    logic [31:0]         r_dr_sh;
    logic                r_byp;
    logic                r_tdo;
    logic [31:0]         r_dbg_wdata;
    logic                r_dbg_wvalid;
    logic                w_sel_idcode, w_sel_dbg;

`ifdef JTAG_TAP_SYNC_EN
    logic [1:0] r_tck_s, r_tms_s, r_tdi_s, r_trstn_s;

    // Reset values keep the TAP idle: tck low, tms high, trstn released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tck_s   <= 2'b00;
            r_tms_s   <= 2'b11;
            r_tdi_s   <= 2'b00;
            r_trstn_s <= 2'b11;
        end else begin
            r_tck_s   <= {r_tck_s[0], tck};
            r_tms_s   <= {r_tms_s[0], tms};
            r_tdi_s   <= {r_tdi_s[0], tdi};
            r_trstn_s <= {r_trstn_s[0], trstn};
        end
    end

    assign w_tck   = r_tck_s[1];
    assign w_tms   = r_tms_s[1];
    assign w_tdi   = r_tdi_s[1];
    assign w_trstn = r_trstn_s[1];
`else
    assign w_tck   = tck;
    assign w_tms   = tms;
    assign w_tdi   = tdi;
    assign w_trstn = trstn;
`endif

    assign w_rise       = w_tck & ~r_tck_q;
    assign w_fall       = ~w_tck & r_tck_q;
    assign w_sel_idcode = (r_ir == INSN_IDCODE);
    assign w_sel_dbg    = (r_ir == INSN_DBG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_TLR;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_trstn) begin
            w_state_nxt = S_TLR;
        end else if (w_rise) begin
            case (r_state)
                S_TLR:     w_state_nxt = w_tms ? S_TLR   : S_RTI;
                S_RTI:     w_state_nxt = w_tms ? S_SELDR : S_RTI;
                S_SELDR:   w_state_nxt = w_tms ? S_SELIR : S_CAPDR;
                S_CAPDR:   w_state_nxt = w_tms ? S_EX1DR : S_SHDR;
                S_SHDR:    w_state_nxt = w_tms ? S_EX1DR : S_SHDR;
                S_EX1DR:   w_state_nxt = w_tms ? S_UPDDR : S_PAUSEDR;
                S_PAUSEDR: w_state_nxt = w_tms ? S_EX2DR : S_PAUSEDR;
                S_EX2DR:   w_state_nxt = w_tms ? S_UPDDR : S_SHDR;
                S_UPDDR:   w_state_nxt = w_tms ? S_SELDR : S_RTI;
                S_SELIR:   w_state_nxt = w_tms ? S_TLR   : S_CAPIR;
                S_CAPIR:   w_state_nxt = w_tms ? S_EX1IR : S_SHIR;
                S_SHIR:    w_state_nxt = w_tms ? S_EX1IR : S_SHIR;
                S_EX1IR:   w_state_nxt = w_tms ? S_UPDIR : S_PAUSEIR;
                S_PAUSEIR: w_state_nxt = w_tms ? S_EX2IR : S_PAUSEIR;
                S_EX2IR:   w_state_nxt = w_tms ? S_UPDIR : S_SHIR;
                S_UPDIR:   w_state_nxt = w_tms ? S_SELDR : S_RTI;
                default:   w_state_nxt = S_TLR;
            endcase
        end
    end

    // Rise: capture/shift in the current state. Fall: drive tdo and perform updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tck_q      <= 1'b0;
            r_ir         <= INSN_IDCODE;
            r_ir_sh      <= '0;
            r_dr_sh      <= '0;
            r_byp        <= 1'b0;
            r_tdo        <= 1'b0;
            r_dbg_wdata  <= '0;
            r_dbg_wvalid <= 1'b0;
        end else begin
            r_tck_q      <= w_tck;
            r_dbg_wvalid <= 1'b0;
            if (!w_trstn) begin
                r_ir <= INSN_IDCODE;
            end else if (w_rise) begin
                case (r_state)
                    S_CAPIR: r_ir_sh <= IR_WIDTH'(2'b01);
                    S_SHIR:  r_ir_sh <= {w_tdi, r_ir_sh[IR_WIDTH-1:1]};
                    S_CAPDR: begin
                        if (w_sel_idcode)   r_dr_sh <= IDCODE;
                        else if (w_sel_dbg) r_dr_sh <= dbg_rdata;
                        else                r_byp   <= 1'b0;
                    end
                    S_SHDR: begin
                        if (w_sel_idcode || w_sel_dbg) r_dr_sh <= {w_tdi, r_dr_sh[31:1]};
                        else                           r_byp   <= w_tdi;
                    end
                    default: ;
                endcase
            end else if (w_fall) begin
                case (r_state)
                    S_SHIR:  r_tdo <= r_ir_sh[0];
                    S_SHDR:  r_tdo <= (w_sel_idcode || w_sel_dbg) ? r_dr_sh[0] : r_byp;
                    S_UPDIR: r_ir  <= r_ir_sh;
                    S_UPDDR: begin
                        if (w_sel_dbg) begin
                            r_dbg_wdata  <= r_dr_sh;
                            r_dbg_wvalid <= 1'b1;
                        end
                    end
                    S_TLR:   r_ir  <= INSN_IDCODE;
                    default: ;
                endcase
            end
        end
    end

    assign tdo        = r_tdo;
    assign dbg_wdata  = r_dbg_wdata;
    assign dbg_wvalid = r_dbg_wvalid;
    assign tap_state  = r_state;
endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Scoreboard bench for jtag_tap_sampled: TCK period 10 clk, pins driven on clk falling edges.
module tb_jtag_tap_sampled;
    localparam logic [3:0] ST_TLR  = 4'hF;
    localparam logic [3:0] ST_RTI  = 4'hC;
    localparam logic [3:0] ST_SHDR = 4'h2;
    localparam logic [31:0] IDC    = 32'h1DEAD3FF;

    logic        clk = 1'b0;
    logic        rst, tck, tms, tdi, trstn;
    logic        tdo, dbg_wvalid;
    logic [31:0] dbg_rdata, dbg_wdata;
    logic [3:0]  tap_state;

    int   n_checks = 0;
    int   n_errors = 0;
    int   wv_cnt   = 0;
    int   wv_long  = 0;
    logic wv_prev  = 1'b0;
    logic exp_q[$];

    always #5 clk = ~clk;

    jtag_tap_sampled dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trstn(trstn),
        .tdo(tdo), .dbg_rdata(dbg_rdata), .dbg_wdata(dbg_wdata),
        .dbg_wvalid(dbg_wvalid), .tap_state(tap_state)
    );

    always @(negedge clk) begin
        if (dbg_wvalid) begin
            wv_cnt++;
            if (wv_prev) wv_long++;
        end
        wv_prev = dbg_wvalid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic m, input logic d);
        tms = m; tdi = d; tck = 1'b1;
        tick(5);
        tck = 1'b0;
        tick(5);
    endtask

    task automatic goto_tlr();
        repeat (5) pulse(1'b1, 1'b0);
    endtask

    task automatic enter_dr();
        pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
    endtask

    task automatic enter_ir();
        pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
    endtask

    // Starts in a Shift state, shifts n bits LSB first, ends in RTI via Update.
    task automatic shift_word(input int n, input logic [31:0] din, input logic [31:0] exp, input string tag);
        logic [31:0] obs_w, exp_w;
        obs_w = '0; exp_w = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
        for (int i = 0; i < n; i++) begin
            obs_w[i] = tdo;
            exp_w[i] = exp_q.pop_front();
            pulse(i == n - 1, din[i]);
        end
        check(tag, obs_w, exp_w);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
    endtask

    initial begin
        int bad_state, bad_tdo;
        logic tdo_ref;
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trstn = 1'b1; dbg_rdata = '0;
        tick(3);
        check("rst_state", 32'(tap_state), 32'(ST_TLR));
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_wdata", dbg_wdata, 32'd0);
        check("rst_wvalid", 32'(dbg_wvalid), 32'd0);
        rst = 1'b0;
        tick(2);

        pulse(1'b0, 1'b0);
        check("to_rti", 32'(tap_state), 32'(ST_RTI));
        enter_dr();
        check("to_shdr", 32'(tap_state), 32'(ST_SHDR));
        goto_tlr();
        check("five_tms_tlr", 32'(tap_state), 32'(ST_TLR));

        // Reset in the middle of a shift
        pulse(1'b0, 1'b0); enter_dr();
        pulse(1'b0, 1'b0); pulse(1'b0, 1'b0);
        rst = 1'b1; tick(1);
        check("rst_mid_state", 32'(tap_state), 32'(ST_TLR));
        check("rst_mid_tdo", 32'(tdo), 32'd0);
        rst = 1'b0; tick(2);

        pulse(1'b0, 1'b0); enter_dr();
        shift_word(32, 32'h0, IDC, "idcode_read");
        check("after_upd_rti", 32'(tap_state), 32'(ST_RTI));

        enter_ir();
        shift_word(5, 32'h1F, 32'h1, "ir_capture");
        enter_dr();
        shift_word(8, 32'hA5, 32'h4A, "bypass_1f");

        enter_ir();
        shift_word(5, 32'h03, 32'h1, "ir_capture_unk");
        enter_dr();
        shift_word(4, 32'hB, 32'h6, "bypass_unk");

        enter_ir();
        shift_word(5, 32'h10, 32'h1, "ir_capture_dbg");
        dbg_rdata = 32'hCAFEF00D;
        wv_cnt = 0; wv_long = 0;
        enter_dr();
        shift_word(32, 32'h12345678, 32'hCAFEF00D, "dbg_read");
        check("dbg_wdata", dbg_wdata, 32'h12345678);
        check("dbg_wvalid_cnt", 32'(wv_cnt), 32'd1);
        check("dbg_wvalid_len", 32'(wv_long), 32'd0);

        // trstn pulse mid-ShDR with IR=DBG
        enter_dr();
        repeat (5) pulse(1'b0, 1'b1);
        trstn = 1'b0; tick(1); trstn = 1'b1;
`ifdef JTAG_TAP_SYNC_EN
        tick(2);
`endif
        check("trst_state", 32'(tap_state), 32'(ST_TLR));
        tick(4);
        check("trst_no_wvalid", 32'(wv_cnt), 32'd1);
        check("trst_wdata_hold", dbg_wdata, 32'h12345678);
        pulse(1'b0, 1'b0); enter_dr();
        shift_word(32, 32'h0, IDC, "idcode_after_trst");

        // trstn overrides a simultaneous rise that would leave RTI
        tms = 1'b1; tck = 1'b1; trstn = 1'b0;
        tick(1); trstn = 1'b1;
        tick(5); tck = 1'b0; tick(5);
        check("trst_over_rise", 32'(tap_state), 32'(ST_TLR));

        // tck held high: pins toggling must not move the TAP
        pulse(1'b0, 1'b0); enter_dr();
        tms = 1'b0; tdi = 1'b1; tck = 1'b1;
        tick(5);
        tdo_ref = tdo;
        bad_state = 0; bad_tdo = 0;
        for (int i = 0; i < 200; i++) begin
            tms = 1'($urandom); tdi = 1'($urandom);
            tick(1);
            if (tap_state !== ST_SHDR) bad_state++;
            if (tdo !== tdo_ref) bad_tdo++;
        end
        check("hold_state", 32'(bad_state), 32'd0);
        check("hold_tdo", 32'(bad_tdo), 32'd0);
        tms = 1'b0; tck = 1'b0; tick(5);
        check("hold_release_state", 32'(tap_state), 32'(ST_SHDR));
        check("hold_release_tdo", 32'(tdo), 32'(IDC[1]));
        goto_tlr();
        check("final_tlr", 32'(tap_state), 32'(ST_TLR));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
